// File: rtl/temp_sense_ctrl.sv
// temp_sense_ctrl: sequences clear/convert cycles on the temperature-sensing diode
// and delivers each 8-bit code to the capture stage with a one-cycle done strobe.
module temp_sense_ctrl #(
    parameter int PERIOD_CYCLES  = 1000000,
    parameter int CLR_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  ts_tempout,
    input  logic        ts_eoc,
    output logic        ts_ce,
    output logic        ts_clr,
    output logic [7:0]  tsdcalo,
    output logic        tsdcaldone,
    output logic        timeout,
    output logic [15:0] sample_count
);
    typedef enum logic [1:0] {IDLE, CLEAR, CONVERT, WAIT} state_t;
    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  eoc_sync;
    logic        eoc_rise;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            eoc_sync     <= '0;
            eoc_rise     <= 1'b0;
            ts_ce        <= 1'b0;
            ts_clr       <= 1'b0;
            tsdcalo      <= '0;
            tsdcaldone   <= 1'b0;
            timeout      <= 1'b0;
            sample_count <= '0;
        end else begin
            // eoc_sync[1] is the synchronised level; eoc_rise is registered, so the FSM acts one edge later
            eoc_sync   <= {eoc_sync[1:0], ts_eoc};
            eoc_rise   <= eoc_sync[1] & ~eoc_sync[2];
            tsdcaldone <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    state  <= CLEAR;
                    ts_clr <= 1'b1;
                    cnt    <= '0;
                end
                CLEAR: if (cnt == 32'(CLR_CYCLES - 1)) begin
                    state  <= CONVERT;
                    ts_clr <= 1'b0;
                    ts_ce  <= 1'b1;
                    cnt    <= '0;
                end else cnt <= cnt + 1;
                CONVERT: if (eoc_rise) begin
                    tsdcalo      <= ts_tempout;
                    tsdcaldone   <= 1'b1;
                    sample_count <= sample_count + 1'b1;
                    ts_ce        <= 1'b0;
                    state        <= WAIT;
                    cnt          <= '0;
                end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    timeout <= 1'b1;
                    ts_ce   <= 1'b0;
                    state   <= WAIT;
                    cnt     <= '0;
                end else cnt <= cnt + 1;
                WAIT: if (cnt == 32'(PERIOD_CYCLES - 1)) begin
                    cnt    <= '0;
                    state  <= enable ? CLEAR : IDLE;
                    ts_clr <= enable;
                end else cnt <= cnt + 1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_temp_sense_ctrl.sv
// tb_temp_sense_ctrl: directed checks of clear/convert timing, strobe latency,
// timeout, ignored EOC pulses, enable drop and mid-conversion reset.
module tb_temp_sense_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ts_tempout = '0;
    logic        ts_eoc = 1'b0;
    logic        ts_ce, ts_clr, tsdcaldone, timeout;
    logic [7:0]  tsdcalo;
    logic [15:0] sample_count;
    int          checks = 0;
    int          errors = 0;
    int          m, n;
    logic        sd, sc, seen;

    temp_sense_ctrl #(.PERIOD_CYCLES(20), .CLR_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ts_tempout(ts_tempout), .ts_eoc(ts_eoc),
        .ts_ce(ts_ce), .ts_clr(ts_clr), .tsdcalo(tsdcalo), .tsdcaldone(tsdcaldone),
        .timeout(timeout), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic cyc_watch(input int k, output logic d, output logic c);
        d = 1'b0;
        c = 1'b0;
        repeat (k) begin
            @(negedge clk);
            d = d | tsdcaldone;
            c = c | ts_clr;
        end
    endtask

    task automatic wait_hi(input string tag, input bit sel_clr, output int k);
        k = 0;
        while ((sel_clr ? ts_clr : ts_ce) !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < 200), 1);
    endtask

    // raise EOC now: first sampled on the next edge, strobe expected three edges after that
    task automatic convert_ok(input logic [7:0] code, input logic [15:0] count);
        ts_tempout = code;
        ts_eoc = 1'b1;
        cyc(3);
        chk("pre_strobe", 32'(tsdcaldone), 0);
        chk("ce_before_strobe", 32'(ts_ce), 1);
        cyc(1);
        chk("strobe", 32'(tsdcaldone), 1);
        chk("tsdcalo", 32'(tsdcalo), 32'(code));
        chk("sample_count", 32'(sample_count), 32'(count));
        chk("ce_drop", 32'(ts_ce), 0);
        ts_eoc = 1'b0;
        cyc(1);
        chk("strobe_single", 32'(tsdcaldone), 0);
    endtask

    initial begin
        cyc(3);
        chk("rst_ce", 32'(ts_ce), 0);
        chk("rst_clr", 32'(ts_clr), 0);
        chk("rst_calo", 32'(tsdcalo), 0);
        chk("rst_done", 32'(tsdcaldone), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_count", 32'(sample_count), 0);

        // first conversion: 4 clear cycles, then convert
        reset = 1'b0;
        enable = 1'b1;
        cyc(1);
        chk("clr_rise", 32'(ts_clr), 1);
        chk("clr_no_ce", 32'(ts_ce), 0);
        n = 0;
        while (ts_clr && n < 100) begin
            n++;
            cyc(1);
        end
        chk("clr_len", 32'(n), 4);
        chk("ce_after_clr", 32'(ts_ce), 1);
        cyc(9);
        convert_ok(8'h5A, 16'd1);
        wait_hi("wait_clr1", 1'b1, m);
        chk("period", 32'(m + 1), 20);

        // second conversion
        wait_hi("wait_ce2", 1'b0, m);
        chk("clr_to_ce", 32'(m), 4);
        cyc(2);
        convert_ok(8'h5B, 16'd2);

        // timeout: EOC never rises
        wait_hi("wait_ce3", 1'b0, m);
        chk("timeout_pre", 32'(timeout), 0);
        n = 0;
        seen = 1'b0;
        while (ts_ce && n < 200) begin
            seen = seen | tsdcaldone;
            n++;
            cyc(1);
        end
        chk("convert_len", 32'(n), 50);
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_no_strobe", 32'(seen | tsdcaldone), 0);
        chk("timeout_calo", 32'(tsdcalo), 'h5B);
        chk("timeout_count", 32'(sample_count), 2);
        wait_hi("wait_clr4", 1'b1, m);
        chk("timeout_period", 32'(m), 20);

        // good conversion after timeout; timeout stays sticky
        wait_hi("wait_ce4", 1'b0, m);
        cyc(2);
        convert_ok(8'h60, 16'd3);
        chk("timeout_sticky", 32'(timeout), 1);

        // EOC pulse during WAIT is ignored
        cyc(2);
        ts_eoc = 1'b1;
        cyc(3);
        ts_eoc = 1'b0;
        cyc_watch(6, sd, sc);
        chk("wait_pulse_strobe", 32'(sd), 0);
        chk("wait_pulse_count", 32'(sample_count), 3);

        // EOC pulse during CLEAR is ignored, then reset mid-CONVERT
        wait_hi("wait_clr5", 1'b1, m);
        ts_eoc = 1'b1;
        cyc(1);
        ts_eoc = 1'b0;
        cyc_watch(5, sd, sc);
        chk("clr_pulse_strobe", 32'(sd), 0);
        chk("clr_pulse_count", 32'(sample_count), 3);
        chk("clr_pulse_ce", 32'(ts_ce), 1);
        reset = 1'b1;
        enable = 1'b0;
        cyc(1);
        chk("mid_rst_ce", 32'(ts_ce), 0);
        chk("mid_rst_clr", 32'(ts_clr), 0);
        chk("mid_rst_calo", 32'(tsdcalo), 0);
        chk("mid_rst_count", 32'(sample_count), 0);
        chk("mid_rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        cyc_watch(5, sd, sc);
        chk("idle_no_strobe", 32'(sd), 0);
        chk("idle_no_clr", 32'(sc), 0);
        chk("idle_no_ce", 32'(ts_ce), 0);

        // edge acted on in the 50th CONVERT cycle wins over timeout
        enable = 1'b1;
        wait_hi("wait_ce6", 1'b0, m);
        chk("idle_to_ce", 32'(m), 5);
        cyc(46);
        convert_ok(8'h33, 16'd1);
        chk("edge_beats_timeout", 32'(timeout), 0);

        // enable dropped mid-CONVERT: finishes, then no further clear
        wait_hi("wait_ce7", 1'b0, m);
        cyc(1);
        enable = 1'b0;
        cyc(1);
        convert_ok(8'h44, 16'd2);
        cyc_watch(40, sd, sc);
        chk("disabled_no_clr", 32'(sc), 0);
        chk("disabled_no_ce", 32'(ts_ce), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/temp_sense_ctrl.md
Name: temp_sense_ctrl

Overview:
- Sequencer between the FPGA hard temperature-sensing diode (TSD) and the TSD capture/CSR stage.
- Periodically clears and starts a TSD conversion, then waits for end-of-conversion (EOC).
- Registers the 8-bit code and presents it as tsdcalo with a one-cycle tsdcaldone strobe, which is the interface the capture stage consumes.
- Also reports a sticky conversion timeout and a conversion counter.

Parameters:
- PERIOD_CYCLES, 1000000: cycles from a tsdcaldone pulse (or a timeout) to the start of the next CLEAR. Must be ≥ 1.
- CLR_CYCLES, 4: cycles ts_clr is held high before each conversion. Must be ≥ 1.
- TIMEOUT_CYCLES, 65536: maximum cycles spent in CONVERT before the conversion is abandoned. Must be ≥ 1.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; allows new conversions to start.
- ts_tempout  in  8  raw TSD code; quasi-static while ts_eoc is high.
- ts_eoc  in  1  TSD end-of-conversion; asynchronous to clk.
- ts_ce  out  1  TSD conversion enable.
- ts_clr  out  1  TSD clear.
- tsdcalo  out  8  last good temperature code; held between samples.
- tsdcaldone  out  1  one-cycle strobe; tsdcalo is new and valid in the same cycle.
- timeout  out  1  sticky; a conversion failed to finish.
- sample_count  out  16  number of successful conversions, wraps.

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE; all counters are cleared.
  - All outputs go to 0, including tsdcalo, timeout and sample_count.
  - Reset mid-conversion drops ts_ce/ts_clr on that same edge; no done pulse follows.
- ts_eoc handling:
  - Passes through a 2-flop synchroniser, then a rising-edge detector on the synchronised value.
  - Edge is detected on the 3rd clk edge after the first edge that samples ts_eoc=1.
  - Edges are acted on only in CONVERT; elsewhere they are ignored.
- IDLE: ts_ce=0, ts_clr=0. If enable=1, go to CLEAR.
- CLEAR:
  - ts_clr=1 and ts_ce=0 for exactly CLR_CYCLES cycles, then go to CONVERT.
  - The enable value is ignored once CLEAR is entered.
- CONVERT:
  - ts_ce=1 and ts_clr=0; the timeout counter counts cycles in this state.
  - On a detected edge, on that edge:
    - tsdcalo <= ts_tempout;
    - tsdcaldone=1 for exactly that one cycle;
    - sample_count increments (0xFFFF -> 0x0000);
    - ts_ce drops to 0; go to WAIT.
  - If the counter reaches TIMEOUT_CYCLES with no edge: timeout <= 1 (sticky until reset), tsdcalo is unchanged, no strobe, ts_ce drops, go to WAIT.
  - An edge arriving in the same cycle the timeout would fire takes priority: it counts as a success and timeout is not set.
  - If ts_eoc is still high on entry to CONVERT (no rising edge), the conversion ends by timeout.
- WAIT:
  - ts_ce=0, ts_clr=0; count PERIOD_CYCLES cycles.
  - On expiry, go to CLEAR if enable=1, else go to IDLE.
  - First ts_clr of the next cycle is asserted exactly PERIOD_CYCLES cycles after the tsdcaldone cycle.
- enable deasserted during CLEAR or CONVERT: the current conversion completes or times out, then WAIT, then IDLE.
- ts_ce and ts_clr are never high together; both are registered outputs.
- tsdcaldone is never high for two consecutive cycles.

Test Plan:
- Parameters PERIOD_CYCLES=20, CLR_CYCLES=4, TIMEOUT_CYCLES=50 for all scenarios unless noted.
- Release reset, enable=1; the TSD model raises ts_eoc 10 cycles after ts_ce with ts_tempout=0x5A.
  -> ts_clr high for exactly 4 cycles, then ts_ce high;
  -> tsdcaldone pulses once, 3 edges after ts_eoc is sampled high;
  -> tsdcalo=0x5A, sample_count=1, ts_ce low from that edge.
- Continue with the model returning 0x5B.
  -> next ts_clr rises exactly 20 cycles after the first tsdcaldone;
  -> second strobe with tsdcalo=0x5B, sample_count=2.
- Model never raises ts_eoc.
  -> after 50 CONVERT cycles: timeout=1, no tsdcaldone, tsdcalo stays 0x5B, sample_count stays 2;
  -> new CLEAR starts 20 cycles later;
  -> a following good conversion (0x60) strobes while timeout remains 1.
- Pulse ts_eoc during WAIT and during CLEAR -> no strobe, no count change.
- Edge detected on the 50th CONVERT cycle (the cycle the timeout would fire) -> success strobe, timeout stays 0.
- Deassert enable mid-CONVERT -> conversion strobes normally, no further ts_clr.
- Assert reset mid-CONVERT -> next edge: ts_ce=0, tsdcalo=0x00, sample_count=0, timeout=0, state IDLE.
